oc8051_cache_ram_bv: RTL and testbench
======================================

// Module: oc8051_cache_ram_bv
// PURPOSE
//  Parametrised dual-port cache data RAM for oc8051_icache, successor to the fixed 32-bit x 128 cache RAM.
//  Port 0 is read-only (fetch side). Port 1 is read/write with byte enables (refill/update side).
//  Adds a valid bit per line, a sequential flush engine and optional per-byte parity.
// PARAMETERS
//  DATA_WIDTH  32  line width in bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
//  ADR_WIDTH   7   address width; DEPTH = 2**ADR_WIDTH lines, indexed 0..DEPTH-1 (no extra entry)
// PORTS
//  clk         in   1           clock; all state on posedge
//  rst         in   1           asynchronous reset, active-low (0 = reset)
//  addr0       in   ADR_WIDTH   port 0 read address
//  data0       out  DATA_WIDTH  port 0 registered read data
//  valid0      out  1           valid bit of the line read on port 0
//  perr0       out  1           parity error on the port 0 read (OC8051_CACHE_PARITY_EN only)
//  addr1       in   ADR_WIDTH   port 1 address
//  data1_i     in   DATA_WIDTH  port 1 write data
//  be1         in   NB          port 1 byte enables, bit k -> data bits [8k+7:8k]
//  wr1         in   1           port 1 write strobe
//  par_inj1    in   1           invert stored parity of byte 0 on this write (OC8051_CACHE_PARITY_EN only)
//  data1_o     out  DATA_WIDTH  port 1 registered read data
//  flush       in   1           start invalidation of all lines
//  busy        out  1           flush in progress
//  flush_done  out  1           one-cycle pulse at end of flush
// BEHAVIOUR
//  Reset (rst=0, async): data0, data1_o = 0; valid0, perr0, busy, flush_done = 0; all valid bits = 0;
//   FSM -> IDLE; flush counter = 0. Data array contents undefined. Reset mid-flush aborts the flush; no done pulse.
//  Latency: both ports return data one clock after address/strobe are sampled.
//  Port 1 write (wr1=1, FSM IDLE): bytes with be1[k]=1 take data1_i; other bytes keep old contents;
//   valid[addr1] <= 1, even when be1=0.
//   data1_o <= merged line (write-first).
//  Port 1 read (wr1=0): data1_o <= mem[addr1].
//  Port 0: data0 <= mem[addr0], valid0 <= valid[addr0].
//   Collision (wr1=1 & addr0==addr1 & IDLE): data0 <= merged line, valid0 <= 1 (bypass).
//  FSM IDLE: flush=1 -> FLUSH, cnt <= 0, busy <= 1.
//  FSM FLUSH: each cycle valid[cnt] <= 0, cnt <= cnt+1.
//   At cnt==DEPTH-1 that line is cleared -> IDLE; busy <= 0 and flush_done <= 1 on the same edge.
//   The flush therefore takes DEPTH cycles of busy=1.
//   flush=1 while in FLUSH is ignored. wr1 in FLUSH is dropped: no array or valid update.
//   data1_o still returns mem[addr1].
//   valid0 is forced 0 in any cycle whose read was sampled in FLUSH. Port 0 data reads proceed normally.
//  Counter wraps naturally; there is no partial-flush state.
//  flush and wr1 in the same IDLE cycle: the write completes, then the flush starts and clears that line too.
// CONFIGURATION
//  OC8051_CACHE_PARITY_EN defined:
//   - One even-parity bit is stored per byte and written with its byte lane.
//   - par_inj1=1 stores the inverted parity for byte 0.
//   - perr0 <= OR over lanes of (recomputed ^ stored) for the word read on port 0.
//     On a bypass collision it is computed from the incoming parity, so par_inj1 flags immediately.
//   - perr0 is qualified by valid: an invalid line never flags.
//  Not defined:
//   - No parity storage. perr0 is tied 0 and par_inj1 is ignored; the ports remain for a uniform interface.
// TESTING
//  1) Reset low mid-traffic -> data0=data1_o=0, busy=0, valid0=0 on next reads of every address.
//  2) Write addr1=5 data1_i=32'hA1B2C3D4 be1=4'hF, next cycle addr0=5 -> data0=A1B2C3D4, valid0=1.
//  3) Then write addr1=5 data1_i=32'h11223344 be1=4'b0101 -> data1_o=A122C344.
//     The same write with addr0=5 -> data0=A122C344 the next cycle (bypass).
//  4) Fill lines 0,63,127 then pulse flush:
//     - busy stays high exactly 128 cycles, with a single flush_done pulse.
//     - A wr1 to line 10 mid-flush is dropped.
//     - Afterwards valid0=0 for all lines, and reads of line 63 still return the old data.
//  5) Assert rst=0 at cycle 40 of a flush -> busy=0 immediately, no flush_done, all valid0=0.
//     A new flush then runs the full 128 cycles.
//  6) [PARITY_EN] Write addr1=3 with par_inj1=1, read addr0=3 -> perr0=1.
//     Rewrite with par_inj1=0 -> perr0=0. Without the macro, perr0 is always 0.

Source files
------------

// File: rtl/oc8051_cache_ram_bv_if.sv
// Bus bundle for the oc8051 icache data RAM: fetch read port 0, refill port 1 and flush control.
// Every input is sampled on each rising clock edge with no backpressure, and every output is
// a registered response that appears one clock after the sample that caused it.
interface oc8051_cache_ram_bv_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 7
);
    localparam int NB = DATA_WIDTH / 8;

    logic [ADR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0] data0;
    logic                  valid0;
    logic                  perr0;
    logic [ADR_WIDTH-1:0]  addr1;
    logic [DATA_WIDTH-1:0] data1_i;
    logic [NB-1:0]         be1;
    logic                  wr1;
    logic                  par_inj1;
    logic [DATA_WIDTH-1:0] data1_o;
    logic                  flush;
    logic                  busy;
    logic                  flush_done;

    modport master (
        output addr0, addr1, data1_i, be1, wr1, par_inj1, flush,
        input  data0, valid0, perr0, data1_o, busy, flush_done
    );

    modport slave (
        input  addr0, addr1, data1_i, be1, wr1, par_inj1, flush,
        output data0, valid0, perr0, data1_o, busy, flush_done
    );
endinterface

// File: rtl/oc8051_cache_ram_bv.sv
// Dual-port oc8051 icache data RAM with per-line valid bits and a sequential flush engine.
// Define OC8051_CACHE_PARITY_EN to store and check one even-parity bit per byte lane.
module oc8051_cache_ram_bv #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    oc8051_cache_ram_bv_if.slave bus,
    output logic                 dbg_state
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADR_WIDTH;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state_q, state_d;
    logic [ADR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic                  valid0_q, valid0_d;
    logic                  perr0_q, perr0_d;
    logic                  wr_en, bypass;
    logic [DATA_WIDTH-1:0] rd1, merged;

    // Writes are only accepted while idle; the merged line feeds the array and both read paths.
    always_comb begin
        wr_en  = bus.wr1 && (state_q == IDLE);
        bypass = wr_en && (bus.addr0 == bus.addr1);
        rd1    = mem[bus.addr1];
        merged = rd1;
        for (int k = 0; k < NB; k++) begin
            if (bus.be1[k]) merged[8*k +: 8] = bus.data1_i[8*k +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        data1_d  = wr_en ? merged : rd1;
        data0_d  = bypass ? merged : mem[bus.addr0];
        valid0_d = (state_q == FLUSH) ? 1'b0 : (bypass | valid_q[bus.addr0]);
        if (wr_en) valid_d[bus.addr1] = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            FLUSH: begin
                valid_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + ADR_WIDTH'(1);
                if (cnt_q == ADR_WIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef OC8051_CACHE_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] par_wr, par_rd0;

    // Stored parity is even parity of the byte; injection flips lane 0 so a read flags it.
    always_comb begin
        par_wr = par_mem[bus.addr1];
        for (int k = 0; k < NB; k++) begin
            if (bus.be1[k]) par_wr[k] = (^bus.data1_i[8*k +: 8]) ^ ((k == 0) & bus.par_inj1);
        end
        par_rd0 = bypass ? par_wr : par_mem[bus.addr0];
        perr0_d = 1'b0;
        for (int k = 0; k < NB; k++) begin
            perr0_d = perr0_d | ((^data0_d[8*k +: 8]) ^ par_rd0[k]);
        end
        perr0_d = perr0_d & valid0_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) par_mem[bus.addr1] <= par_wr;
    end
`else
    logic unused_par_inj;
    assign unused_par_inj = bus.par_inj1;
    assign perr0_d        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
            valid0_q <= 1'b0;
            perr0_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            valid0_q <= valid0_d;
            perr0_q  <= perr0_d;
        end
    end

    // The data array has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[bus.addr1] <= merged;
    end

    assign bus.data0      = data0_q;
    assign bus.valid0     = valid0_q;
    assign bus.perr0      = perr0_q;
    assign bus.data1_o    = data1_q;
    assign bus.busy       = busy_q;
    assign bus.flush_done = done_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_oc8051_cache_ram_bv.sv
// Self-checking bench for oc8051_cache_ram_bv: directed scenarios plus randomized traffic
// compared against a line/byte level reference model of the cache RAM.
module tb_oc8051_cache_ram_bv;
    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int NB    = 4;
    localparam int DEPTH = 128;
`ifdef OC8051_CACHE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dbg_state;
    int   tests = 0;
    int   fails = 0;

    oc8051_cache_ram_bv_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) bus();

    oc8051_cache_ram_bv #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: line contents, which bytes are known, valid bits, lane-0 parity poison.
    logic [DW-1:0] m_mem   [DEPTH];
    logic [NB-1:0] m_known [DEPTH];
    bit            m_valid [DEPTH];
    bit            m_bad   [DEPTH];
    bit            m_flushing;
    int            m_fidx;

    logic [DW-1:0] exp_data0, exp_data1;
    logic [NB-1:0] exp_known0, exp_known1;
    bit            exp_valid0, exp_perr0, exp_perr_chk, exp_busy, exp_done;

    function automatic logic [DW-1:0] bmask(input logic [NB-1:0] k);
        logic [DW-1:0] m;
        for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_known[i] = '0;
            m_bad[i]   = 1'b0;
            m_mem[i]   = '0;
        end
        m_flushing = 1'b0;
        m_fidx     = 0;
    endtask

    // Drives one cycle, advances the model, and returns 1 ns after the sampling edge.
    task automatic step(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [DW-1:0] d,
                        input logic [NB-1:0] be, input bit wr, input bit pinj, input bit fl);
        logic [DW-1:0] merged;
        logic [NB-1:0] mk;
        bit            wr_ok, byp, bad0;
        bus.addr0    = a0;
        bus.addr1    = a1;
        bus.data1_i  = d;
        bus.be1      = be;
        bus.wr1      = wr;
        bus.par_inj1 = pinj;
        bus.flush    = fl;
        wr_ok  = wr && !m_flushing;
        merged = m_mem[a1];
        mk     = m_known[a1];
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = d[8*k +: 8];
                mk[k]            = 1'b1;
            end
        end
        byp          = wr_ok && (a0 == a1);
        exp_data1    = wr_ok ? merged : m_mem[a1];
        exp_known1   = wr_ok ? mk : m_known[a1];
        exp_data0    = byp ? merged : m_mem[a0];
        exp_known0   = byp ? mk : m_known[a0];
        exp_valid0   = m_flushing ? 1'b0 : (byp ? 1'b1 : m_valid[a0]);
        bad0         = byp ? (be[0] ? pinj : m_bad[a1]) : m_bad[a0];
        exp_perr0    = PAR_EN && exp_valid0 && bad0;
        exp_perr_chk = !exp_valid0 || (exp_known0 == '1);
        if (wr_ok) begin
            m_mem[a1]   = merged;
            m_known[a1] = mk;
            m_valid[a1] = 1'b1;
            if (be[0]) m_bad[a1] = pinj;
        end
        exp_done = 1'b0;
        if (m_flushing) begin
            m_valid[m_fidx] = 1'b0;
            m_fidx++;
            if (m_fidx == DEPTH) begin
                m_flushing = 1'b0;
                exp_done   = 1'b1;
            end
        end else if (fl) begin
            m_flushing = 1'b1;
            m_fidx     = 0;
        end
        exp_busy = m_flushing;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Counts busy samples and done pulses until busy drops, bounded; optional mid-flush write to line 10.
    task automatic run_flush(input bit poke, input logic [DW-1:0] pdata,
                             output int busy_cyc, output int done_cnt, output bit fell, output bit done_at_fall);
        busy_cyc = 0; done_cnt = 0; fell = 1'b0; done_at_fall = 1'b0;
        step('0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 300 && !fell; c++) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.flush_done === 1'b1) done_cnt++;
            if (bus.busy !== 1'b1) begin
                fell         = 1'b1;
                done_at_fall = bus.flush_done;
            end else begin
                step(AW'($urandom_range(0, DEPTH - 1)), (poke && c == 20) ? AW'(10) : AW'($urandom_range(0, DEPTH - 1)),
                     pdata, 4'hF, poke && (c == 20), 1'b0, c == 50);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_step();
        idle_step();
        if (bus.data0 !== '0)      begin fails++; $display("FAIL reset_data0 got %h want 0", bus.data0); end
        if (bus.data1_o !== '0)    begin fails++; $display("FAIL reset_data1 got %h want 0", bus.data1_o); end
        if (bus.valid0 !== 1'b0)   begin fails++; $display("FAIL reset_valid0 got %b want 0", bus.valid0); end
        if (bus.perr0 !== 1'b0)    begin fails++; $display("FAIL reset_perr0 got %b want 0", bus.perr0); end
        if (bus.busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.flush_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.flush_done); end
        tests += 6;
        rst = 1'b1;
        for (int i = 0; i < 30; i++)
            step(AW'(i), AW'(i), $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        tests += 4;
        if (bus.data0 !== '0)    begin fails++; $display("FAIL midreset_data0 got %h want 0", bus.data0); end
        if (bus.data1_o !== '0)  begin fails++; $display("FAIL midreset_data1 got %h want 0", bus.data1_o); end
        if (bus.valid0 !== 1'b0) begin fails++; $display("FAIL midreset_valid0 got %b want 0", bus.valid0); end
        if (bus.busy !== 1'b0)   begin fails++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step(AW'(i), AW'(i), '0, '0, 1'b0, 1'b0, 1'b0);
            tests++;
            if (bus.valid0 !== 1'b0) begin fails++; $display("FAIL postreset_valid0 line %0d got %b want 0", i, bus.valid0); end
        end
    endtask

    task automatic test_write_merge();
        step(AW'(0), AW'(5), 32'hA1B2C3D4, 4'hF, 1'b1, 1'b0, 1'b0);
        tests++;
        if (bus.data1_o !== 32'hA1B2C3D4) begin fails++; $display("FAIL wr_full_data1 got %h want a1b2c3d4", bus.data1_o); end
        step(AW'(5), AW'(0), '0, '0, 1'b0, 1'b0, 1'b0);
        tests += 2;
        if (bus.data0 !== 32'hA1B2C3D4) begin fails++; $display("FAIL rd_full_data0 got %h want a1b2c3d4", bus.data0); end
        if (bus.valid0 !== 1'b1)        begin fails++; $display("FAIL rd_full_valid0 got %b want 1", bus.valid0); end
        step(AW'(5), AW'(5), 32'h11223344, 4'b0101, 1'b1, 1'b0, 1'b0);
        tests += 3;
        if (bus.data1_o !== 32'hA122C344) begin fails++; $display("FAIL merge_data1 got %h want a122c344", bus.data1_o); end
        if (bus.data0 !== 32'hA122C344)   begin fails++; $display("FAIL bypass_data0 got %h want a122c344", bus.data0); end
        if (bus.valid0 !== 1'b1)          begin fails++; $display("FAIL bypass_valid0 got %b want 1", bus.valid0); end
        step(AW'(5), AW'(5), '0, '0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.data1_o !== 32'hA122C344) begin fails++; $display("FAIL merge_readback got %h want a122c344", bus.data1_o); end
        step(AW'(0), AW'(20), 32'hDEADBEEF, 4'h0, 1'b1, 1'b0, 1'b0);
        step(AW'(20), AW'(0), '0, '0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.valid0 !== 1'b1) begin fails++; $display("FAIL be0_sets_valid got %b want 1", bus.valid0); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] d63, d10;
        int            busy_cyc, done_cnt;
        bit            fell, done_at_fall;
        d63 = $urandom;
        d10 = $urandom;
        step(AW'(0), AW'(0), $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
        step(AW'(0), AW'(63), d63, 4'hF, 1'b1, 1'b0, 1'b0);
        step(AW'(0), AW'(127), $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
        step(AW'(0), AW'(10), d10, 4'hF, 1'b1, 1'b0, 1'b0);
        run_flush(1'b1, ~d10, busy_cyc, done_cnt, fell, done_at_fall);
        tests += 4;
        if (!fell)          begin fails++; $display("FAIL flush_timeout busy never dropped within 300 cycles"); end
        if (busy_cyc != DEPTH) begin fails++; $display("FAIL flush_busy_len got %0d want %0d", busy_cyc, DEPTH); end
        if (done_cnt != 1)  begin fails++; $display("FAIL flush_done_count got %0d want 1", done_cnt); end
        if (!done_at_fall)  begin fails++; $display("FAIL flush_done_align got 0 want 1 when busy drops"); end
        idle_step();
        tests++;
        if (bus.flush_done !== 1'b0) begin fails++; $display("FAIL flush_done_width got %b want 0", bus.flush_done); end
        for (int i = 0; i < DEPTH; i++) begin
            step(AW'(i), AW'(i), '0, '0, 1'b0, 1'b0, 1'b0);
            tests++;
            if (bus.valid0 !== 1'b0) begin fails++; $display("FAIL flushed_valid0 line %0d got %b want 0", i, bus.valid0); end
        end
        step(AW'(63), AW'(10), '0, '0, 1'b0, 1'b0, 1'b0);
        tests += 2;
        if (bus.data0 !== d63)   begin fails++; $display("FAIL flush_keeps_data got %h want %h", bus.data0, d63); end
        if (bus.data1_o !== d10) begin fails++; $display("FAIL flush_drops_write got %h want %h", bus.data1_o, d10); end
    endtask

    task automatic test_reset_mid_flush();
        int busy_cyc, done_cnt, spur;
        bit fell, done_at_fall;
        step(AW'(0), AW'(100), $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
        step('0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (39) idle_step();
        #2 rst = 1'b0;
        #1;
        tests += 2;
        if (bus.busy !== 1'b0)       begin fails++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        if (bus.flush_done !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", bus.flush_done); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        spur = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            step(AW'(i % DEPTH), AW'(0), '0, '0, 1'b0, 1'b0, 1'b0);
            if (bus.flush_done !== 1'b0 || bus.busy !== 1'b0 || bus.valid0 !== 1'b0) spur++;
        end
        tests++;
        if (spur != 0) begin fails++; $display("FAIL abort_quiet got %0d bad cycles want 0", spur); end
        run_flush(1'b0, '0, busy_cyc, done_cnt, fell, done_at_fall);
        tests += 2;
        if (busy_cyc != DEPTH) begin fails++; $display("FAIL reflush_busy_len got %0d want %0d", busy_cyc, DEPTH); end
        if (done_cnt != 1)     begin fails++; $display("FAIL reflush_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_parity();
        step(AW'(0), AW'(3), $urandom, 4'hF, 1'b1, 1'b1, 1'b0);
        step(AW'(3), AW'(0), '0, '0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.perr0 !== PAR_EN) begin fails++; $display("FAIL parity_inject got %b want %b", bus.perr0, PAR_EN); end
        step(AW'(0), AW'(3), $urandom, 4'hF, 1'b1, 1'b0, 1'b0);
        step(AW'(3), AW'(0), '0, '0, 1'b0, 1'b0, 1'b0);
        tests++;
        if (bus.perr0 !== 1'b0) begin fails++; $display("FAIL parity_clean got %b want 0", bus.perr0); end
        step(AW'(3), AW'(3), $urandom, 4'hF, 1'b1, 1'b1, 1'b0);
        tests++;
        if (bus.perr0 !== PAR_EN) begin fails++; $display("FAIL parity_bypass got %b want %b", bus.perr0, PAR_EN); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a0, a1;
        for (int n = 0; n < 1500; n++) begin
            a0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
            step(a0, a1, $urandom, NB'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
            tests += 5;
            if ((bus.data0 & bmask(exp_known0)) !== (exp_data0 & bmask(exp_known0)))
                begin fails++; $display("FAIL rnd_data0 n=%0d got %h want %h", n, bus.data0, exp_data0); end
            if ((bus.data1_o & bmask(exp_known1)) !== (exp_data1 & bmask(exp_known1)))
                begin fails++; $display("FAIL rnd_data1 n=%0d got %h want %h", n, bus.data1_o, exp_data1); end
            if (bus.valid0 !== exp_valid0)
                begin fails++; $display("FAIL rnd_valid0 n=%0d got %b want %b", n, bus.valid0, exp_valid0); end
            if (bus.busy !== exp_busy)
                begin fails++; $display("FAIL rnd_busy n=%0d got %b want %b", n, bus.busy, exp_busy); end
            if (bus.flush_done !== exp_done)
                begin fails++; $display("FAIL rnd_done n=%0d got %b want %b", n, bus.flush_done, exp_done); end
            if (exp_perr_chk) begin
                tests++;
                if (bus.perr0 !== exp_perr0)
                    begin fails++; $display("FAIL rnd_perr0 n=%0d got %b want %b", n, bus.perr0, exp_perr0); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_merge();
        test_flush();
        test_reset_mid_flush();
        test_parity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
